axis_traffic_gen: RTL

- AXI-Stream master that generates deterministic test traffic: a programmed number of packets of programmed length, with optional idle gaps.
- Transmit-side counterpart to the passive stream monitor.
- Used on the far end of a link under test, so monitor flit/packet counts can be checked against generator counts.

---
 rtl/axis_traffic_gen.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/axis_traffic_gen.sv
// ----------------------------------------------------------------------------
// axis_traffic_gen
//
// AXI-Stream master that emits deterministic test traffic. Each run sends a
// programmed number of packets, each a programmed number of flits long, with
// an optional idle gap after every packet except the last. The flit and packet
// counters report what the downstream sink accepted, so they can be compared
// with a stream monitor at the far end of a link.
//
// Build option:
//   AXIS_TRAFFIC_GEN_LFSR_EN - when defined, the payload is a 64-bit Fibonacci
//                              LFSR (taps 64,63,61,60, seed 1). When undefined,
//                              the payload is the flit index since start.
//
// Ports:
//   clk, rstn          clock; synchronous active-low reset
//   start              single-cycle launch pulse (ignored while busy)
//   cfg_pkt_len        flits per packet (0 is treated as 1)
//   cfg_pkt_count      packets per run (0 completes with no traffic)
//   cfg_gap            idle cycles after each packet
//   cfg_dest/id/user   sideband values for the run
//   M_*                AXI-Stream master; tdata is the 64-bit payload
//                      replicated across all lanes, tkeep all ones
//   busy, done         run status
//   flit_count         flits accepted this run
//   packet_count       packets accepted this run
// ----------------------------------------------------------------------------
module axis_traffic_gen #(
    parameter int DATAWIDTH = 512,
    parameter int DESTWIDTH = 8,
    parameter int USERWIDTH = 8,
    parameter int IDWIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [15:0]            cfg_pkt_len,
    input  logic [31:0]            cfg_pkt_count,
    input  logic [7:0]             cfg_gap,
    input  logic [DESTWIDTH-1:0]   cfg_dest,
    input  logic [IDWIDTH-1:0]     cfg_id,
    input  logic [USERWIDTH-1:0]   cfg_user,
    output logic [DATAWIDTH-1:0]   M_tdata,
    output logic [DATAWIDTH/8-1:0] M_tkeep,
    output logic [DESTWIDTH-1:0]   M_tdest,
    output logic [IDWIDTH-1:0]     M_tid,
    output logic [USERWIDTH-1:0]   M_tuser,
    output logic                   M_tlast,
    output logic                   M_tvalid,
    input  logic                   M_tready,
    output logic                   busy,
    output logic                   done,
    output logic [63:0]            flit_count,
    output logic [63:0]            packet_count
);

    localparam int LANES = DATAWIDTH / 64;
    localparam int KEEPW = DATAWIDTH / 8;

`ifdef AXIS_TRAFFIC_GEN_LFSR_EN
    localparam logic [63:0] PAYLOAD_SEED = 64'd1;
`else
    localparam logic [63:0] PAYLOAD_SEED = 64'd0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Advance the 64-bit payload word by one accepted flit.
    function automatic logic [63:0] payload_step(input logic [63:0] cur);
`ifdef AXIS_TRAFFIC_GEN_LFSR_EN
        payload_step = {cur[62:0], cur[63] ^ cur[62] ^ cur[60] ^ cur[59]};
`else
        payload_step = cur + 64'd1;
`endif
    endfunction

    state_t                 state_q,    state_d;
    logic [15:0]            len_q,      len_d;
    logic [31:0]            left_q,     left_d;
    logic [7:0]             gap_q,      gap_d;
    logic [7:0]             gap_cnt_q,  gap_cnt_d;
    logic [DESTWIDTH-1:0]   dest_q,     dest_d;
    logic [IDWIDTH-1:0]     id_q,       id_d;
    logic [USERWIDTH-1:0]   user_q,     user_d;
    logic [15:0]            beat_q,     beat_d;
    logic [63:0]            payload_q,  payload_d;
    logic [63:0]            flit_cnt_q, flit_cnt_d;
    logic [63:0]            pkt_cnt_q,  pkt_cnt_d;
    logic                   tvalid_q,   tvalid_d;
    logic                   tlast_q,    tlast_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic                   hs_s;

    assign hs_s = tvalid_q & M_tready;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        left_d     = left_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        dest_d     = dest_q;
        id_d       = id_q;
        user_d     = user_q;
        beat_d     = beat_q;
        payload_d  = payload_q;
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    len_d      = (cfg_pkt_len == 16'd0) ? 16'd1 : cfg_pkt_len;
                    left_d     = cfg_pkt_count;
                    gap_d      = cfg_gap;
                    gap_cnt_d  = 8'd0;
                    dest_d     = cfg_dest;
                    id_d       = cfg_id;
                    user_d     = cfg_user;
                    beat_d     = 16'd0;
                    payload_d  = PAYLOAD_SEED;
                    flit_cnt_d = 64'd0;
                    pkt_cnt_d  = 64'd0;
                    if (cfg_pkt_count == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_SEND: begin
                if (hs_s) begin
                    flit_cnt_d = flit_cnt_q + 64'd1;
                    payload_d  = payload_step(payload_q);
                    if (tlast_q) begin
                        pkt_cnt_d = pkt_cnt_q + 64'd1;
                        beat_d    = 16'd0;
                        if (left_q == 32'd1) begin
                            left_d  = 32'd0;
                            state_d = ST_DONE;
                        end else begin
                            left_d = left_q - 32'd1;
                            if (gap_q != 8'd0) begin
                                gap_cnt_d = gap_q;
                                state_d   = ST_GAP;
                            end else begin
                                state_d = ST_SEND;
                            end
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                // The cycle holding count 1 is the last idle one.
                if (gap_cnt_q <= 8'd1) begin
                    gap_cnt_d = 8'd0;
                    state_d   = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output flags are decoded from next-state values so they can be flopped.
        tvalid_d = (state_d == ST_SEND);
        busy_d   = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d   = (state_d == ST_DONE);
        tlast_d  = (state_d == ST_SEND) && (beat_d == (len_d - 16'd1));
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            len_q      <= 16'd0;
            left_q     <= 32'd0;
            gap_q      <= 8'd0;
            gap_cnt_q  <= 8'd0;
            dest_q     <= '0;
            id_q       <= '0;
            user_q     <= '0;
            beat_q     <= 16'd0;
            payload_q  <= 64'd0;
            flit_cnt_q <= 64'd0;
            pkt_cnt_q  <= 64'd0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            left_q     <= left_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            dest_q     <= dest_d;
            id_q       <= id_d;
            user_q     <= user_d;
            beat_q     <= beat_d;
            payload_q  <= payload_d;
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign M_tdata      = {LANES{payload_q}};
    assign M_tkeep      = {KEEPW{tvalid_q}};
    assign M_tdest      = dest_q;
    assign M_tid        = id_q;
    assign M_tuser      = user_q;
    assign M_tlast      = tlast_q;
    assign M_tvalid     = tvalid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign flit_count   = flit_cnt_q;
    assign packet_count = pkt_cnt_q;

endmodule
